// File: rtl/rename_state_unit.sv
// Rename state for the out-of-order core: free list of physical tags,
// architectural-to-physical map table with ready bits, and the physical
// register file. Lookups and reads are combinational on registered state,
// with same-cycle CDB and write-data bypasses. All updates are registered.
//
// Physical tag 0 is reserved for x0. It is never freed, never written and
// always reads as zero, so x0 stays mapped to tag 0 and ready.

module rename_state_unit #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int XLEN      = 32,
    parameter int PR_W      = 6
) (
    input  logic                          clock,
    input  logic                          reset,

    // allocation (dispatch)
    input  logic                          alloc_en,
    output logic                          alloc_ok,
    output logic [PR_W-1:0]               alloc_pr,

    // rename and source lookup
    input  logic                          rename_en,
    input  logic [$clog2(ARCH_REGS)-1:0]  rename_ar,
    input  logic [PR_W-1:0]               rename_pr,
    output logic [PR_W-1:0]               told_pr,
    input  logic [$clog2(ARCH_REGS)-1:0]  rs1_ar,
    input  logic [$clog2(ARCH_REGS)-1:0]  rs2_ar,
    output logic [PR_W-1:0]               rs1_pr,
    output logic [PR_W-1:0]               rs2_pr,
    output logic                          rs1_rdy,
    output logic                          rs2_rdy,

    // completion broadcast
    input  logic                          cdb_en,
    input  logic [PR_W-1:0]               cdb_tag,

    // retire
    input  logic                          free_en,
    input  logic [PR_W-1:0]               free_pr,

    // physical register file
    input  logic [PR_W-1:0]               rd1_idx,
    input  logic [PR_W-1:0]               rd2_idx,
    output logic [XLEN-1:0]               rd1_data,
    output logic [XLEN-1:0]               rd2_data,
    input  logic                          wr_en,
    input  logic [PR_W-1:0]               wr_idx,
    input  logic [XLEN-1:0]               wr_data
);

    localparam int AR_W = $clog2(ARCH_REGS);

    // Free list starts with every tag above the architectural range.
    localparam int FREE_INIT = PHYS_REGS - ARCH_REGS;

    localparam logic [PR_W:0]   CNT_FULL  = (PR_W+1)'(PHYS_REGS);
    localparam logic [PR_W:0]   CNT_INIT  = (PR_W+1)'(FREE_INIT);
    localparam logic [PR_W-1:0] TAIL_INIT = PR_W'(FREE_INIT);

    // ------------------------------------------------------------------
    // Free list: circular FIFO, depth PHYS_REGS, pointers wrap naturally
    // because PHYS_REGS is a power of two and the pointers are PR_W wide.
    // ------------------------------------------------------------------
    logic [PR_W-1:0] fl_mem [PHYS_REGS];
    logic [PR_W-1:0] fl_head;
    logic [PR_W-1:0] fl_tail;
    logic [PR_W:0]   fl_count;
    logic            do_alloc;
    logic            do_free;

    // Availability comes from registered count only; a same-cycle free
    // does not make an empty list allocatable.
    always_comb begin
        alloc_ok = (fl_count != '0);
        alloc_pr = fl_mem[fl_head];
        do_alloc = alloc_en && (fl_count != '0);
        do_free  = free_en && (free_pr != '0) && (fl_count != CNT_FULL);
    end

    // Free-list storage and pointers; push at tail, pop at head.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                if (i < FREE_INIT)
                    fl_mem[i] <= PR_W'(i + ARCH_REGS);
                else
                    fl_mem[i] <= '0;
            end
            fl_head  <= '0;
            fl_tail  <= TAIL_INIT;
            fl_count <= CNT_INIT;
        end else begin
            if (do_free) begin
                fl_mem[fl_tail] <= free_pr;
                fl_tail         <= fl_tail + 1'b1;
            end
            if (do_alloc)
                fl_head <= fl_head + 1'b1;
            case ({do_alloc, do_free})
                2'b10:   fl_count <= fl_count - 1'b1;
                2'b01:   fl_count <= fl_count + 1'b1;
                default: fl_count <= fl_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Map table with ready bits.
    // ------------------------------------------------------------------
    logic [PR_W-1:0]      map_tag [ARCH_REGS];
    logic [ARCH_REGS-1:0] map_rdy;
    logic                 rename_act;

    // Lookups see the pre-rename mapping; a CDB hit on the looked-up tag
    // makes the source ready in the same cycle.
    always_comb begin
        rename_act = rename_en && (rename_ar != '0);
        told_pr    = map_tag[rename_ar];
        rs1_pr     = map_tag[rs1_ar];
        rs2_pr     = map_tag[rs2_ar];
        rs1_rdy    = map_rdy[rs1_ar] || (cdb_en && (cdb_tag == map_tag[rs1_ar]));
        rs2_rdy    = map_rdy[rs2_ar] || (cdb_en && (cdb_tag == map_tag[rs2_ar]));
    end

    // Map update: CDB sets ready on every matching entry, then a rename of
    // the same entry overrides it so the new tag starts not-ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < ARCH_REGS; r++)
                map_tag[r] <= PR_W'(r);
            map_rdy <= '1;
        end else begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                if (cdb_en && (map_tag[r] == cdb_tag))
                    map_rdy[r] <= 1'b1;
                if (rename_act && (rename_ar == AR_W'(r))) begin
                    map_tag[r] <= rename_pr;
                    map_rdy[r] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Physical register file.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] prf [PHYS_REGS];
    logic            wr_act;

    // Combinational reads with write-through bypass; tag 0 is hardwired 0.
    always_comb begin
        wr_act = wr_en && (wr_idx != '0);

        if (rd1_idx == '0)
            rd1_data = '0;
        else if (wr_act && (wr_idx == rd1_idx))
            rd1_data = wr_data;
        else
            rd1_data = prf[rd1_idx];

        if (rd2_idx == '0)
            rd2_data = '0;
        else if (wr_act && (wr_idx == rd2_idx))
            rd2_data = wr_data;
        else
            rd2_data = prf[rd2_idx];
    end

    // Registered PRF write; entry 0 is never written.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PHYS_REGS; i++)
                prf[i] <= '0;
        end else if (wr_act) begin
            prf[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rename_state_unit.sv
// Directed bench for rename_state_unit: a table of single-cycle vectors
// followed by hand-written free-list and mid-sequence reset sequences.

module tb_rename_state_unit;

    logic        clock;
    logic        reset;
    logic        alloc_en;
    logic        alloc_ok;
    logic [5:0]  alloc_pr;
    logic        rename_en;
    logic [4:0]  rename_ar;
    logic [5:0]  rename_pr;
    logic [5:0]  told_pr;
    logic [4:0]  rs1_ar, rs2_ar;
    logic [5:0]  rs1_pr, rs2_pr;
    logic        rs1_rdy, rs2_rdy;
    logic        cdb_en;
    logic [5:0]  cdb_tag;
    logic        free_en;
    logic [5:0]  free_pr;
    logic [5:0]  rd1_idx, rd2_idx;
    logic [31:0] rd1_data, rd2_data;
    logic        wr_en;
    logic [5:0]  wr_idx;
    logic [31:0] wr_data;

    int total = 0;
    int bad   = 0;

    rename_state_unit dut (
        .clock     (clock),
        .reset     (reset),
        .alloc_en  (alloc_en),
        .alloc_ok  (alloc_ok),
        .alloc_pr  (alloc_pr),
        .rename_en (rename_en),
        .rename_ar (rename_ar),
        .rename_pr (rename_pr),
        .told_pr   (told_pr),
        .rs1_ar    (rs1_ar),
        .rs2_ar    (rs2_ar),
        .rs1_pr    (rs1_pr),
        .rs2_pr    (rs2_pr),
        .rs1_rdy   (rs1_rdy),
        .rs2_rdy   (rs2_rdy),
        .cdb_en    (cdb_en),
        .cdb_tag   (cdb_tag),
        .free_en   (free_en),
        .free_pr   (free_pr),
        .rd1_idx   (rd1_idx),
        .rd2_idx   (rd2_idx),
        .rd1_data  (rd1_data),
        .rd2_data  (rd2_data),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        alloc_en;
        logic        rename_en;
        logic [4:0]  rename_ar;
        logic [5:0]  rename_pr;
        logic [4:0]  rs1_ar;
        logic [4:0]  rs2_ar;
        logic        cdb_en;
        logic [5:0]  cdb_tag;
        logic        wr_en;
        logic [5:0]  wr_idx;
        logic [31:0] wr_data;
        logic [5:0]  rd1_idx;
        logic [5:0]  rd2_idx;
        logic        e_alloc_ok;
        logic [5:0]  e_alloc_pr;
        logic [5:0]  e_told;
        logic [5:0]  e_rs1_pr;
        logic        e_rs1_rdy;
        logic [5:0]  e_rs2_pr;
        logic        e_rs2_rdy;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t base(input logic [5:0] apr);
        vec_t v;
        v            = '0;
        v.e_alloc_ok = 1'b1;
        v.e_alloc_pr = apr;
        v.e_rs1_rdy  = 1'b1;
        v.e_rs2_rdy  = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        alloc_en  = 0; rename_en = 0; rename_ar = 0; rename_pr = 0;
        rs1_ar    = 0; rs2_ar    = 0; cdb_en    = 0; cdb_tag   = 0;
        free_en   = 0; free_pr   = 0; rd1_idx   = 0; rd2_idx   = 0;
        wr_en     = 0; wr_idx    = 0; wr_data   = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vec_t v;
        reset = 1'b1;
        idle();

        // v0: post-reset idle
        v = base(32); v.rs1_ar = 3; v.e_rs1_pr = 3; v.rd1_idx = 5; vecs.push_back(v);
        // v1: alloc + rename x2 -> 32; sources and told see old mapping
        v = base(32); v.alloc_en = 1; v.rename_en = 1; v.rename_ar = 2; v.rename_pr = 32;
        v.rs1_ar = 2; v.rs2_ar = 2; v.e_told = 2; v.e_rs1_pr = 2; v.e_rs2_pr = 2; vecs.push_back(v);
        // v2: new mapping visible, not ready
        v = base(33); v.rename_ar = 2; v.e_told = 32; v.rs1_ar = 2; v.e_rs1_pr = 32; v.e_rs1_rdy = 0;
        v.rs2_ar = 3; v.e_rs2_pr = 3; vecs.push_back(v);
        // v3: CDB tag 32 bypasses ready in the same cycle
        v = base(33); v.cdb_en = 1; v.cdb_tag = 32; v.rs1_ar = 2; v.e_rs1_pr = 32;
        v.rs2_ar = 5; v.e_rs2_pr = 5; vecs.push_back(v);
        // v4: ready bit now stored
        v = base(33); v.rs1_ar = 2; v.e_rs1_pr = 32; vecs.push_back(v);
        // v5: PRF write bypass
        v = base(33); v.wr_en = 1; v.wr_idx = 40; v.wr_data = 32'hDEADBEEF;
        v.rd1_idx = 40; v.e_rd1 = 32'hDEADBEEF; v.rd2_idx = 41; vecs.push_back(v);
        // v6: write persisted
        v = base(33); v.rd1_idx = 40; v.e_rd1 = 32'hDEADBEEF; vecs.push_back(v);
        // v7: write to tag 0 is not bypassed
        v = base(33); v.wr_en = 1; v.wr_idx = 0; v.wr_data = 32'h1234;
        v.rd2_idx = 40; v.e_rd2 = 32'hDEADBEEF; vecs.push_back(v);
        // v8: write to tag 0 not stored
        v = base(33); vecs.push_back(v);
        // v9: rename of x0 ignored
        v = base(33); v.rename_en = 1; v.rename_ar = 0; v.rename_pr = 33; vecs.push_back(v);
        // v10: x0 still tag 0 ready
        v = base(33); vecs.push_back(v);
        // v11: rename x7 -> 33
        v = base(33); v.alloc_en = 1; v.rename_en = 1; v.rename_ar = 7; v.rename_pr = 33;
        v.e_told = 7; v.rs1_ar = 7; v.e_rs1_pr = 7; vecs.push_back(v);
        // v12: rename x7 -> 34 while CDB completes 33: bypass now, rename wins at edge
        v = base(34); v.alloc_en = 1; v.rename_en = 1; v.rename_ar = 7; v.rename_pr = 34;
        v.cdb_en = 1; v.cdb_tag = 33; v.e_told = 33;
        v.rs1_ar = 7; v.e_rs1_pr = 33; v.rs2_ar = 7; v.e_rs2_pr = 33; vecs.push_back(v);
        // v13: x7 -> 34 not ready; unrelated CDB tag does not bypass
        v = base(35); v.cdb_en = 1; v.cdb_tag = 40; v.rs1_ar = 7; v.e_rs1_pr = 34; v.e_rs1_rdy = 0;
        v.rs2_ar = 7; v.e_rs2_pr = 34; v.e_rs2_rdy = 0; vecs.push_back(v);

        do_reset();

        foreach (vecs[k]) begin
            v = vecs[k];
            alloc_en  = v.alloc_en;  rename_en = v.rename_en;
            rename_ar = v.rename_ar; rename_pr = v.rename_pr;
            rs1_ar    = v.rs1_ar;    rs2_ar    = v.rs2_ar;
            cdb_en    = v.cdb_en;    cdb_tag   = v.cdb_tag;
            wr_en     = v.wr_en;     wr_idx    = v.wr_idx;  wr_data = v.wr_data;
            rd1_idx   = v.rd1_idx;   rd2_idx   = v.rd2_idx;
            free_en   = 0;           free_pr   = 0;
            #1;
            chk($sformatf("v%0d alloc_ok", k), 32'(alloc_ok), 32'(v.e_alloc_ok));
            chk($sformatf("v%0d alloc_pr", k), 32'(alloc_pr), 32'(v.e_alloc_pr));
            chk($sformatf("v%0d told_pr", k),  32'(told_pr),  32'(v.e_told));
            chk($sformatf("v%0d rs1_pr", k),   32'(rs1_pr),   32'(v.e_rs1_pr));
            chk($sformatf("v%0d rs1_rdy", k),  32'(rs1_rdy),  32'(v.e_rs1_rdy));
            chk($sformatf("v%0d rs2_pr", k),   32'(rs2_pr),   32'(v.e_rs2_pr));
            chk($sformatf("v%0d rs2_rdy", k),  32'(rs2_rdy),  32'(v.e_rs2_rdy));
            chk($sformatf("v%0d rd1_data", k), rd1_data,      v.e_rd1);
            chk($sformatf("v%0d rd2_data", k), rd2_data,      v.e_rd2);
            tick();
        end

        // Reset asserted mid-operation while other operations are requested.
        idle();
        alloc_en = 1; rename_en = 1; rename_ar = 3; rename_pr = 35;
        wr_en = 1; wr_idx = 40; wr_data = 32'h5; cdb_en = 1; cdb_tag = 34;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        rs1_ar = 3; rs2_ar = 7; rd1_idx = 40; rename_ar = 2;
        #1;
        chk("rst alloc_ok", 32'(alloc_ok), 32'd1);
        chk("rst alloc_pr", 32'(alloc_pr), 32'd32);
        chk("rst rs1_pr",   32'(rs1_pr),   32'd3);
        chk("rst rs1_rdy",  32'(rs1_rdy),  32'd1);
        chk("rst rs2_pr",   32'(rs2_pr),   32'd7);
        chk("rst rs2_rdy",  32'(rs2_rdy),  32'd1);
        chk("rst told_pr",  32'(told_pr),  32'd2);
        chk("rst rd1_data", rd1_data,      32'd0);
        tick();

        // Drain the free list completely.
        idle();
        for (int i = 0; i < 32; i++) begin
            alloc_en = 1;
            #1;
            chk($sformatf("drain%0d alloc_ok", i), 32'(alloc_ok), 32'd1);
            chk($sformatf("drain%0d alloc_pr", i), 32'(alloc_pr), 32'(32 + i));
            tick();
        end
        #1;
        chk("empty alloc_ok", 32'(alloc_ok), 32'd0);
        tick();                                   // alloc on empty, ignored
        alloc_en = 0;
        free_en = 1; free_pr = 2;
        #1;
        chk("free no bypass alloc_ok", 32'(alloc_ok), 32'd0);
        tick();
        free_en = 1; free_pr = 0;                 // freeing tag 0 is ignored
        #1;
        chk("after free alloc_ok", 32'(alloc_ok), 32'd1);
        chk("after free alloc_pr", 32'(alloc_pr), 32'd2);
        tick();
        alloc_en = 1; free_en = 1; free_pr = 5;   // simultaneous: count stays 1
        #1;
        chk("alloc+free alloc_pr", 32'(alloc_pr), 32'd2);
        tick();
        free_en = 0; free_pr = 0;
        #1;
        chk("post a+f alloc_ok", 32'(alloc_ok), 32'd1);
        chk("post a+f alloc_pr", 32'(alloc_pr), 32'd5);
        tick();
        alloc_en = 0;
        #1;
        chk("final empty alloc_ok", 32'(alloc_ok), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
